// File: rtl/nand2_stim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nand2_stim
// Description : Self-sequencing NAND2 exercise block. A stimulus sequencer
//               walks (a,b) through 00,01,10,11 into a NAND core, and a
//               golden-table checker flags any mismatch. An external-operand
//               mode drives the core directly.
// Revision    : 1.0 - initial release
// ============================================================================
module nand2_stim #(
   parameter int HOLD_CYCLES = 10,
   parameter bit CONTINUOUS  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       ext_sel,
   input  logic       ext_a,
   input  logic       ext_b,
   output logic       a,
   output logic       b,
   output logic       y,
   output logic [1:0] vec,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] c_last_hold = 8'(HOLD_CYCLES - 1);
   // Expected y indexed by vec: vectors 0..2 give 1, vector 3 gives 0.
   localparam logic [3:0] c_golden    = 4'b0111;

   logic       r_rst_sync_n;
   logic       r_core_en;
   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_vec;
   logic [1:0] w_vec_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic       r_err;
   logic       w_hold_end;
   logic       w_start_acc;
   logic       w_mismatch;
   logic       w_ext_en;

   // Reset asserts asynchronously; release is retimed so the first
   // functional edge is the second rising clk after rst_n goes high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_sync_n <= 1'b0;
      end else begin
         r_rst_sync_n <= 1'b1;
      end
   end

   // Keeps the external operand path quiet while the block is in reset.
   always_ff @(posedge clk or negedge r_rst_sync_n) begin
      if (!r_rst_sync_n) begin
         r_core_en <= 1'b0;
      end else begin
         r_core_en <= 1'b1;
      end
   end

   assign w_hold_end  = (r_cnt == c_last_hold);
   assign w_start_acc = (r_state == S_IDLE) && start && !stop;

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (stop) begin
         w_state_nxt = S_IDLE;
         w_vec_nxt   = 2'd0;
         w_cnt_nxt   = 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_vec_nxt = 2'd0;
               w_cnt_nxt = 8'd0;
               if (start) begin
                  w_state_nxt = S_APPLY;
               end
            end
            S_APPLY: begin
               if (w_hold_end) begin
                  w_cnt_nxt = 8'd0;
                  if (r_vec == 2'd3) begin
                     w_vec_nxt  = 2'd0;
                     w_done_nxt = 1'b1;
                     if (!CONTINUOUS) begin
                        w_state_nxt = S_DONE;
                     end
                  end else begin
                     w_vec_nxt = r_vec + 2'd1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 2'd0;
               w_cnt_nxt   = 8'd0;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_vec_nxt   = 2'd0;
               w_cnt_nxt   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge r_rst_sync_n) begin
      if (!r_rst_sync_n) begin
         r_state <= S_IDLE;
         r_vec   <= 2'd0;
         r_cnt   <= 8'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // The checker reads the core output port itself so a fault on y is seen.
   assign w_mismatch = busy && !ext_sel && (y != c_golden[r_vec]);

   always_ff @(posedge clk or negedge r_rst_sync_n) begin
      if (!r_rst_sync_n) begin
         r_err <= 1'b0;
      end else if (w_start_acc) begin
         r_err <= 1'b0;
      end else if (w_mismatch) begin
         r_err <= 1'b1;
      end
   end

   assign w_ext_en = ext_sel && r_core_en;
   assign a        = w_ext_en ? ext_a : r_vec[1];
   assign b        = w_ext_en ? ext_b : r_vec[0];
   assign y        = ~(a & b);
   assign vec      = r_vec;
   assign busy     = (r_state == S_APPLY);
   assign done     = r_done;
   assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nand2_stim.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for nand2_stim: a single-pass instance (HOLD_CYCLES=10) and a
// continuous instance (HOLD_CYCLES=1) compared against an arithmetic model.
module tb_nand2_stim;

   localparam int H = 10;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic       start_c = 1'b0;
   logic       stop_c  = 1'b0;
   logic       ext_sel = 1'b0;
   logic       ext_a   = 1'b0;
   logic       ext_b   = 1'b0;
   logic       a, b, y, busy, done, err;
   logic [1:0] vec;
   logic       a_c, b_c, y_c, busy_c, done_c, err_c;
   logic [1:0] vec_c;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nand2_stim #(.HOLD_CYCLES(H), .CONTINUOUS(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .ext_sel(ext_sel), .ext_a(ext_a), .ext_b(ext_b),
      .a(a), .b(b), .y(y), .vec(vec), .busy(busy), .done(done), .err(err)
   );

   nand2_stim #(.HOLD_CYCLES(1), .CONTINUOUS(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c),
      .ext_sel(ext_sel), .ext_a(ext_a), .ext_b(ext_b),
      .a(a_c), .b(b_c), .y(y_c), .vec(vec_c), .busy(busy_c), .done(done_c), .err(err_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: vector index is elapsed cycles / hold, modulo 4; y is NAND.
   task automatic chk_pass(input int t);
      int ev;
      ev = (t / H) % 4;
      chk("vec", 32'(vec), ev);
      chk("a", 32'(a), ev / 2);
      chk("b", 32'(b), ev % 2);
      chk("y", 32'(y), 1 - (ev / 2) * (ev % 2));
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a"}, 32'(a), 0);
      chk({tag, "_b"}, 32'(b), 0);
      chk({tag, "_y"}, 32'(y), 1);
      chk({tag, "_vec"}, 32'(vec), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held with random inputs
      rst_n = 1'b0;
      repeat (4) begin
         {start, stop, start_c, stop_c, ext_sel, ext_a, ext_b} = 7'($urandom);
         tick();
         chk_reset_vals("rst");
         chk("rst_c_a", 32'(a_c), 0);
         chk("rst_c_busy", 32'(busy_c), 0);
      end
      {start, stop, start_c, stop_c, ext_sel, ext_a, ext_b} = 7'd0;
      #2 rst_n = 1'b1;
      repeat (3) tick();

      // Single pass, random start pulses while busy must be ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 4 * H; t++) begin
         chk_pass(t);
         chk("pass_err", 32'(err), 0);
         start = (t < 4 * H - 2) && ($urandom_range(0, 3) == 0);
         ext_a = 1'($urandom);
         ext_b = 1'($urandom);
         tick();
      end
      start = 1'b0;
      chk("pass_done", 32'(done), 1);
      chk("pass_done_busy", 32'(busy), 0);
      chk("pass_done_err", 32'(err), 0);
      tick();
      chk("pass_end_done", 32'(done), 0);
      chk("pass_end_busy", 32'(busy), 0);

      // Simultaneous start and stop in IDLE
      start = 1'b1; stop = 1'b1; start_c = 1'b1; stop_c = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0; start_c = 1'b0; stop_c = 1'b0;
      chk("ss_busy", 32'(busy), 0);
      chk("ss_busy_c", 32'(busy_c), 0);

      // Continuous mode: stop on the cycle that would wrap
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      for (int t = 0; t < 8; t++) begin
         chk("cont_vec", 32'(vec_c), t % 4);
         chk("cont_y", 32'(y_c), 1 - ((t % 4) / 2) * ((t % 4) % 2));
         chk("cont_busy", 32'(busy_c), 1);
         chk("cont_done", 32'(done_c), (t > 0 && t % 4 == 0) ? 1 : 0);
         if (t == 7) stop_c = 1'b1;
         tick();
      end
      stop_c = 1'b0;
      chk("cont_stop_busy", 32'(busy_c), 0);
      chk("cont_stop_vec", 32'(vec_c), 0);
      chk("cont_stop_done", 32'(done_c), 0);
      chk("cont_err", 32'(err_c), 0);
      tick();
      chk("cont_trail_done", 32'(done_c), 0);

      // External mode while idle: combinational sweep, no clock
      ext_sel = 1'b1;
      begin
         int rot;
         rot = int'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) begin
            int k;
            k = (i + rot) % 4;
            ext_a = 1'(k / 2);
            ext_b = 1'(k % 2);
            #1;
            chk("ext_a", 32'(a), k / 2);
            chk("ext_b", 32'(b), k % 2);
            chk("ext_y", 32'(y), 1 - (k / 2) * (k % 2));
            chk("ext_y_c", 32'(y_c), 1 - (k / 2) * (k % 2));
         end
      end
      chk("ext_err", 32'(err), 0);
      ext_sel = 1'b0;

      // Pass with random ext_sel toggling: sequencer undisturbed, checker off
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 4 * H; t++) begin
         if (ext_sel) begin
            chk("mix_vec", 32'(vec), (t / H) % 4);
            chk("mix_busy", 32'(busy), 1);
            chk("mix_a", 32'(a), 32'(ext_a));
            chk("mix_y", 32'(y), 1 - int'(ext_a) * int'(ext_b));
         end else begin
            chk_pass(t);
         end
         chk("mix_err", 32'(err), 0);
         ext_sel = 1'($urandom);
         ext_a   = 1'($urandom);
         ext_b   = 1'($urandom);
         tick();
      end
      ext_sel = 1'b0;
      chk("mix_done", 32'(done), 1);
      tick();

      // Abort with stop at vec=2
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 2 * H + 3; t++) begin
         chk_pass(t);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_vec", 32'(vec), 0);
      chk("abort_done", 32'(done), 0);
      tick();
      chk("abort_trail_done", 32'(done), 0);

      // Reset mid-pass at vec=1, asynchronous
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < H + 2; t++) begin
         chk_pass(t);
         tick();
      end
      chk("pre_rst_b", 32'(b), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");

      // Release with start held: second edge after release starts the pass
      start = 1'b1;
      #2 rst_n = 1'b1;
      tick();
      chk("rel_edge1_busy", 32'(busy), 0);
      tick();
      chk("rel_edge2_busy", 32'(busy), 1);
      start = 1'b0;

      // Fault injection on y during vec=3
      for (int t = 0; t < 3 * H + 1; t++) begin
         chk_pass(t);
         chk("flt_err_pre", 32'(err), 0);
         tick();
      end
      force dut.y = 1'b1;
      tick();
      chk("flt_err_set", 32'(err), 1);
      release dut.y;
      repeat (4 * H - (3 * H + 2)) tick();
      chk("flt_done", 32'(done), 1);
      chk("flt_err_sticky", 32'(err), 1);
      tick();
      chk("flt_err_idle", 32'(err), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("flt_err_clear", 32'(err), 0);
      chk("flt_restart_busy", 32'(busy), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("final_busy", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nand2_stim.md
# nand2_stim

Self-sequencing NAND2 exercise block: a clocked stimulus sequencer drives the operand pair (a, b) through all four input combinations into a 2-input NAND core. The core output y is checked against a golden truth table on every cycle. It is a bring-up/self-test primitive. It sits beside logic-library cells so that gate function can be exercised on silicon or in simulation without an external bench. An external-operand mode lets the same NAND core be driven directly.

## Interface
- HOLD_CYCLES, default 10: cycles each vector is held; legal range 1..255.
- CONTINUOUS, default 0: 0 = one pass per start; 1 = wrap from vector 3 back to vector 0 until stop.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a pass; ignored while busy.
- stop  in  1  aborts a pass or continuous run; returns to IDLE next edge.
- ext_sel  in  1  1 = NAND core fed from ext_a/ext_b instead of the sequencer.
- ext_a, ext_b  in  1 each  external operands.
- a, b  out  1 each  operands currently applied to the core.
- y  out  1  NAND result, combinational: y = ~(a & b).
- vec  out  2  index of current vector, {A,B} encoding.
- busy  out  1  high while sequencing.
- done  out  1  one-cycle pulse at end of a pass.
- err  out  1  sticky mismatch flag.

## Operation
- Core: y = ~(a & b), purely combinational, no X propagation beyond the inputs.
- Operand mux: when ext_sel=1, a=ext_a and b=ext_b combinationally. When ext_sel=0, a=vec[1] and b=vec[0], registered.
- Vector order: 0:(a=0,b=0) → 1:(0,1) → 2:(1,0) → 3:(1,1). Expected y values in that order: 1, 1, 1, 0.
- FSM states:
  - IDLE: busy=0, vec=0, hold counter=0.
  - APPLY: busy=1. The hold counter counts 0..HOLD_CYCLES-1. At HOLD_CYCLES-1, vec increments and the counter clears.
  - DONE: single cycle, done=1, then IDLE.
- Transitions:
  - IDLE→APPLY on start; err clears on the same edge.
  - APPLY at vec=3 with the last hold cycle: CONTINUOUS=0 → DONE; CONTINUOUS=1 → vec wraps to 0, pulses done for one cycle, and stays in APPLY.
  - Any state→IDLE when stop=1. stop has priority over start and over hold expiry. An aborted pass raises no done.
- Checker: every cycle with busy=1 and ext_sel=0, compare y with the golden table entry for vec. On mismatch, err is set and held until the next accepted start or reset.
- The checker is disabled when ext_sel=1. Switching ext_sel mid-pass does not disturb the sequencer state.

## Timing
- Reset (async, rst_n=0) values: a=0, b=0, y=1, vec=0, busy=0, done=0, err=0, FSM=IDLE, counter=0. rst_n deassertion is synchronised; first functional edge is the second rising clk after release.
- Latency: start sampled at edge N; busy=1 and vec=0 from edge N.
- Vector k is applied over edges N+k·HOLD_CYCLES .. N+(k+1)·HOLD_CYCLES-1.
- done pulses during the cycle after the final hold cycle, i.e. at edge N+4·HOLD_CYCLES; busy=0 in that cycle.
- Total pass time is 4·HOLD_CYCLES+1 cycles start-to-IDLE.
- y follows a/b in the same cycle, with zero clock latency.
- start while busy is ignored, with no restart and no err clear.
- Simultaneous start and stop in IDLE: remain IDLE.
- Reset mid-pass: immediate return to reset values; no done.

## Test plan
- Reset: hold rst_n=0 with random inputs → a=0, b=0, y=1, busy=0, done=0, err=0.
- Single pass, HOLD_CYCLES=10: start pulse → (a,b,y) = (0,0,1), (0,1,1), (1,0,1), (1,1,0), each for 10 cycles; done=1 at cycle 40 after start; err stays 0.
- Continuous mode, CONTINUOUS=1, HOLD_CYCLES=1: start → vec sequence 0,1,2,3,0,1…, with a done pulse at each wrap; stop → IDLE next edge, vec=0, no trailing done.
- External mode: ext_sel=1, sweep ext_a/ext_b over 00, 01, 10, 11 → y = 1, 1, 1, 0 in the same cycle; err unchanged.
- Abort and reset mid-pass: stop at vec=2 → busy=0 with no done. Restart, then drop rst_n at vec=1 → outputs take reset values asynchronously.
- Checker sanity: force y to 1 during vec=3 (fault injection) → err=1 and sticky through done; next start clears err.
